pc_fetch_ctrl: RTL

Program-counter sequencer and instruction-fetch controller. Owns the 32-bit PC and issues word-aligned fetches to instruction memory over a req/ack handshake. Presents each fetched instruction to decode over a valid/ready handshake. Applies branch/jump redirects, traps and halt/resume with fixed priority; sits between the execute stage, instruction memory and decode.

---
 rtl/pc_ctrl_pkg.sv | 16 +
 rtl/pc_next_sel.sv | 50 +++++
 rtl/pc_fetch_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter fetch controller.
package pc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_HOLD   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/pc_next_sel.sv
// Priority mux for the next PC: trap > misaligned redirect > redirect > pc+4 > hold.
module pc_next_sel
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic        trap,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] pc,
    input  logic        advance,
    input  logic        instr_valid,
    input  logic [31:0] instr_pc,
    output logic [31:0] pc_next,
    output logic        flush,
    output logic        epc_load,
    output logic [31:0] epc_value,
    output logic        misalign
);

    // Select the next PC and the side effects of the winning event
    always_comb begin
        pc_next   = pc;
        flush     = 1'b0;
        epc_load  = 1'b0;
        epc_value = pc;
        misalign  = 1'b0;
        if (trap) begin
            pc_next   = TRAP_VECTOR;
            flush     = 1'b1;
            epc_load  = 1'b1;
            epc_value = instr_valid ? instr_pc : pc;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            // A misaligned target is a trap that records the bad target
            pc_next   = TRAP_VECTOR;
            flush     = 1'b1;
            epc_load  = 1'b1;
            epc_value = redirect_target;
            misalign  = 1'b1;
        end else if (redirect_valid) begin
            pc_next   = redirect_target;
            flush     = 1'b1;
        end else if (advance) begin
            pc_next   = pc + INSTR_BYTES;
        end else begin
            pc_next   = pc;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and instruction-fetch controller: imem req/ack on one side,
// decode valid/ready on the other, with redirect/trap/halt handling.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] epc,
    output logic        misalign_err
);

    fetch_state_e state_r, state_nxt_s;
    logic [31:0]  pc_r, pc_nxt_s, epc_value_s;
    logic         advance_s, flush_s, epc_load_s, misalign_s;
    logic         imem_req_nxt_s, instr_valid_nxt_s;
    logic [31:0]  imem_addr_nxt_s, instr_nxt_s, instr_pc_nxt_s;

    assign advance_s = (state_r == ST_REQ) && imem_ack;

    pc_next_sel #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_pc_next_sel (
        .trap            (trap),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc_r),
        .advance         (advance_s),
        .instr_valid     (instr_valid),
        .instr_pc        (instr_pc),
        .pc_next         (pc_nxt_s),
        .flush           (flush_s),
        .epc_load        (epc_load_s),
        .epc_value       (epc_value_s),
        .misalign        (misalign_s)
    );

    // Next-state and next-output logic for the fetch FSM
    always_comb begin
        state_nxt_s       = state_r;
        imem_req_nxt_s    = imem_req;
        imem_addr_nxt_s   = imem_addr;
        instr_valid_nxt_s = instr_valid;
        instr_nxt_s       = instr;
        instr_pc_nxt_s    = instr_pc;
        case (state_r)
            ST_IDLE: begin
                if (flush_s || !halt) begin
                    state_nxt_s     = ST_REQ;
                    imem_req_nxt_s  = 1'b1;
                    imem_addr_nxt_s = pc_nxt_s;
                end else begin
                    state_nxt_s     = ST_HALTED;
                    imem_req_nxt_s  = 1'b0;
                end
            end
            ST_REQ: begin
                if (flush_s) begin
                    // Without an ack the request must finish untouched in DRAIN
                    if (imem_ack) begin
                        state_nxt_s     = ST_REQ;
                        imem_addr_nxt_s = pc_nxt_s;
                    end else begin
                        state_nxt_s     = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    state_nxt_s       = ST_HOLD;
                    imem_req_nxt_s    = 1'b0;
                    instr_valid_nxt_s = 1'b1;
                    instr_nxt_s       = imem_rdata;
                    instr_pc_nxt_s    = pc_r;
                end else begin
                    state_nxt_s       = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (flush_s) begin
                    state_nxt_s       = ST_REQ;
                    instr_valid_nxt_s = 1'b0;
                    imem_req_nxt_s    = 1'b1;
                    imem_addr_nxt_s   = pc_nxt_s;
                end else if (instr_ready) begin
                    instr_valid_nxt_s = 1'b0;
                    if (halt) begin
                        state_nxt_s     = ST_HALTED;
                        imem_req_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s     = ST_REQ;
                        imem_req_nxt_s  = 1'b1;
                        imem_addr_nxt_s = pc_r;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    state_nxt_s     = ST_REQ;
                    imem_addr_nxt_s = pc_nxt_s;
                end else begin
                    state_nxt_s     = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                // Plain redirects only retarget the PC; trap-class events restart fetching
                if (epc_load_s || resume) begin
                    state_nxt_s     = ST_REQ;
                    imem_req_nxt_s  = 1'b1;
                    imem_addr_nxt_s = pc_nxt_s;
                end else begin
                    state_nxt_s     = ST_HALTED;
                end
            end
            default: begin
                state_nxt_s       = ST_IDLE;
                imem_req_nxt_s    = 1'b0;
                instr_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, PC and registered output updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_VECTOR;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_VECTOR;
            instr_valid  <= 1'b0;
            instr        <= 32'h0000_0000;
            instr_pc     <= 32'h0000_0000;
            epc          <= 32'h0000_0000;
            misalign_err <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            imem_req     <= imem_req_nxt_s;
            imem_addr    <= imem_addr_nxt_s;
            instr_valid  <= instr_valid_nxt_s;
            instr        <= instr_nxt_s;
            instr_pc     <= instr_pc_nxt_s;
            epc          <= epc_load_s ? epc_value_s : epc;
            misalign_err <= misalign_s;
        end
    end

endmodule
